// File: rtl/ysyx_040750_trap_ctrl_pkg.sv
// Shared definitions for the trap/return sequencer: cause codes, CSR addresses and FSM encodings.
package ysyx_040750_trap_ctrl_pkg;

  localparam int          DEF_PC_W        = 32;
  localparam int          DEF_XLEN        = 64;
  localparam logic [63:0] DEF_ECALL_CAUSE = 64'd11;
  localparam logic [63:0] DEF_TIMER_CAUSE = 64'h8000_0000_0000_0007;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_MRET  = 2'd1,
    EV_ECALL = 2'd2,
    EV_TIMER = 2'd3
  } trap_event_e;

endpackage

// File: rtl/ysyx_040750_trap_ctrl.sv
// Trap/return sequencer: commits ecall, mret and timer interrupts at WB, strobes the CSR file,
// flushes the pipeline, waits for the LSU to drain and hands the redirect PC to the IFU.
module ysyx_040750_trap_ctrl
  import ysyx_040750_trap_ctrl_pkg::*;
#(
  parameter int          PC_W        = DEF_PC_W,
  parameter int          XLEN        = DEF_XLEN,
  parameter logic [63:0] ECALL_CAUSE = DEF_ECALL_CAUSE,
  parameter logic [63:0] TIMER_CAUSE = DEF_TIMER_CAUSE
) (
  input  logic            I_sys_clk,
  input  logic            I_rst_n,
  input  logic            I_wb_valid,
  input  logic            I_wb_ecall,
  input  logic            I_wb_mret,
  input  logic [PC_W-1:0] I_wb_pc,
  input  logic [PC_W-1:0] I_wb_dnpc,
  input  logic            I_timer_intr,
  input  logic            I_lsu_busy,
  input  logic [XLEN-1:0] I_csr_rd_data,
  input  logic            I_ifu_ready,
  output logic            O_csr_intr_wr,
  output logic            O_csr_intr_rd,
  output logic            O_csr_mret_wr,
  output logic            O_csr_mret_rd,
  output logic [PC_W-1:0] O_intr_pc,
  output logic [XLEN-1:0] O_intr_no,
  output logic            O_flush,
  output logic            O_stall,
  output logic            O_redirect_valid,
  output logic [PC_W-1:0] O_redirect_pc
);

  trap_state_e     state_r, next_state_s;
  trap_event_e     event_s;
  logic [PC_W-1:0] target_r, target_s, mtvec_base_s;
  logic            load_s;
  logic            unused_s;

  // mtvec is direct mode only, so the low two bits never reach the PC
  assign mtvec_base_s = {I_csr_rd_data[PC_W-1:2], 2'b00};
  assign unused_s     = ^I_csr_rd_data[XLEN-1:PC_W];

  // State and redirect-target registers
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r  <= ST_IDLE;
      target_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        target_r <= target_s;
      end
    end
  end

  // Event detect with mret > ecall > timer priority; reset masks it so no strobe leaks out
  always_comb begin
    event_s = EV_NONE;
    if (I_rst_n && I_wb_valid && (state_r == ST_IDLE)) begin
      if (I_wb_mret) begin
        event_s = EV_MRET;
      end else if (I_wb_ecall) begin
        event_s = EV_ECALL;
      end else if (I_timer_intr) begin
        event_s = EV_TIMER;
      end else begin
        event_s = EV_NONE;
      end
    end else begin
      event_s = EV_NONE;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state_s     = state_r;
    load_s           = 1'b0;
    target_s         = '0;
    O_csr_intr_wr    = 1'b0;
    O_csr_intr_rd    = 1'b0;
    O_csr_mret_wr    = 1'b0;
    O_csr_mret_rd    = 1'b0;
    O_intr_pc        = '0;
    O_intr_no        = '0;
    O_flush          = 1'b0;
    O_stall          = 1'b0;
    O_redirect_valid = 1'b0;
    O_redirect_pc    = '0;
    case (state_r)
      ST_IDLE: begin
        case (event_s)
          EV_MRET: begin
            O_csr_mret_wr = 1'b1;
            O_csr_mret_rd = 1'b1;
            target_s      = I_csr_rd_data[PC_W-1:0];
          end
          EV_ECALL: begin
            O_csr_intr_wr = 1'b1;
            O_csr_intr_rd = 1'b1;
            O_intr_pc     = I_wb_pc;
            O_intr_no     = ECALL_CAUSE[XLEN-1:0];
            target_s      = mtvec_base_s;
          end
          EV_TIMER: begin
            // The interrupted instruction commits, so mepc gets its successor
            O_csr_intr_wr = 1'b1;
            O_csr_intr_rd = 1'b1;
            O_intr_pc     = I_wb_dnpc;
            O_intr_no     = TIMER_CAUSE[XLEN-1:0];
            target_s      = mtvec_base_s;
          end
          default: begin
            target_s = '0;
          end
        endcase
        if (event_s != EV_NONE) begin
          O_flush      = 1'b1;
          load_s       = 1'b1;
          next_state_s = I_lsu_busy ? ST_DRAIN : ST_REDIRECT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        O_stall = 1'b1;
        if (!I_lsu_busy) begin
          next_state_s = ST_REDIRECT;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_REDIRECT: begin
        O_stall          = 1'b1;
        O_redirect_valid = 1'b1;
        O_redirect_pc    = target_r;
        if (I_ifu_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_REDIRECT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

endmodule
